store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store entries; a power of two, at least 2.
REQ-002 The block SHALL have one clock and one reset. The reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  synchronous reset, active-low.
REQ-005 st_valid  in  1  MEM stage presents a store.
REQ-006 st_ready  out  1  buffer accepts a store this cycle.
REQ-007 st_addr  in  32  byte address of the store.
REQ-008 st_sel  in  4  size code: 0001 = byte, 0011 = half, 1111 = word.
REQ-009 st_data  in  32  unaligned register value (LSB-justified).
REQ-010 st_addr_err  out  1  one-cycle pulse: misaligned or illegal store rejected.
REQ-011 ram_req  out  1  write request to data RAM.
REQ-012 ram_addr  out  32  word address; bits [1:0] are always 00.
REQ-013 ram_wstrb  out  4  byte-lane write enables.
REQ-014 ram_wdata  out  32  lane-aligned write data.
REQ-015 ram_ack  in  1  RAM accepted the current request.
REQ-016 ld_addr  in  32  byte address of a load in MEM.
REQ-017 ld_hit  out  1  combinational: a valid entry matches the load word address (ld_addr[31:2]); the load stalls.
REQ-018 buf_empty  out  1  no valid entries.
REQ-019 buf_count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-020 Accept handshake:
- A store is accepted on a rising edge where st_valid & st_ready.
- st_ready = (buf_count < DEPTH); it does not depend on same-cycle ram_ack.
REQ-021 Alignment rules (lane = st_addr[1:0]):
- byte: wstrb = 0001 << lane; wdata = st_data[7:0] replicated to all four lanes.
- half with st_addr[0]=0: wstrb = 0011 if st_addr[1]=0, else 1100; wdata = {st_data[15:0], st_data[15:0]}.
- word with lane = 00: wstrb = 1111; wdata = st_data.
REQ-022 Rejected stores:
- Cases: half with st_addr[0]=1; word with lane != 00; any other st_sel value.
- The store is consumed (st_ready honoured) but not enqueued.
- st_addr_err pulses high for the cycle after acceptance.
- buf_count does not change.
REQ-023 Entries are stored as {addr[31:2], wstrb, wdata}. They drain in strict FIFO order, and the write pointer wraps modulo DEPTH.
REQ-024 Drain FSM:
- IDLE: ram_req = 0. Go to SEND when buf_count > 0 at the clock edge.
- SEND: ram_req = 1; ram_addr, ram_wstrb and ram_wdata come from the head entry and stay stable until ram_ack.
- On ram_ack in SEND: pop the head. Stay in SEND if entries remain after the pop, otherwise go to IDLE.
- Back-to-back requests have no bubble.
REQ-025 ram_ack in IDLE SHALL be ignored.
REQ-026 Latency: a store accepted at edge N into an empty buffer raises ram_req in the cycle after edge N.
REQ-027 buf_count update per edge:
- +1 on a valid enqueue; −1 on pop; unchanged when both occur in the same edge.
- It never exceeds DEPTH and never underflows.
REQ-028 ld_hit compares ld_addr[31:2] against every valid entry, including the head in SEND. A newly accepting store becomes visible from the cycle after acceptance.
REQ-029 buf_empty = (buf_count == 0).
REQ-030 The read pointer wraps modulo DEPTH independently of the write pointer.

Reset
REQ-031 While resetn = 0 at a rising edge, all of the following are cleared:
- pointers, buf_count and entry valid bits;
- FSM goes to IDLE;
- ram_req = 0, st_addr_err = 0;
- ram_addr, ram_wstrb and ram_wdata = 0.
REQ-032 Reset mid-request (SEND, no ack yet) discards all entries. ram_req is 0 the cycle after the reset edge, and no pop is recorded.
REQ-033 After reset release: st_ready = 1, buf_empty = 1, ld_hit = 0.

Verification
REQ-034 Byte store:
- Stimulus: st_addr=0x8000_0013, st_sel=0001, st_data=0x0000_00A5.
- Response: the next cycle shows ram_req=1, ram_addr=0x8000_0010, ram_wstrb=1000, ram_wdata=0xA5A5_A5A5.
REQ-035 Half store:
- Stimulus: addr 0x...02, data 0x1234_BEEF.
- Response: wstrb=1100, wdata=0xBEEF_BEEF.
REQ-036 Misaligned stores:
- Stimulus: a half store at 0x...01, then a word store at 0x...02.
- Response: st_addr_err pulses twice, buf_count stays 0, ram_req stays 0.
REQ-037 Fill and stall:
- Stimulus: 4 word stores with ram_ack held low.
- Response: buf_count=4, st_ready=0 and a 5th store stalls.
- Then pulse ram_ack one cycle: ram_req stays 1 with the second entry presented, and the 5th store is accepted at the following edge.
REQ-038 Forwarding hazard:
- Stimulus: pending store at 0x100 with ld_addr=0x103.
- Response: ld_hit=1; with ld_addr=0x104, ld_hit=0.
- After ram_ack drains the entry, ld_hit=0.
REQ-039 Reset mid-request:
- Stimulus: 3 entries, SEND, resetn=0 for one edge.
- Response: buf_count=0, ram_req=0, buf_empty=1, and a later ram_ack has no effect.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store port, data RAM write port, and
// load hazard probe, bundled for a single module port.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [3:0]    st_sel;
  logic [31:0]   st_data;
  logic          st_addr_err;
  logic          ram_req;
  logic [31:0]   ram_addr;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_wdata;
  logic          ram_ack;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic          buf_empty;
  logic [CW-1:0] buf_count;

  modport master (
    output st_valid, st_addr, st_sel, st_data,
    output ram_ack, ld_addr,
    input  st_ready, st_addr_err,
    input  ram_req, ram_addr, ram_wstrb, ram_wdata,
    input  ld_hit, buf_empty, buf_count
  );

  modport slave (
    input  st_valid, st_addr, st_sel, st_data,
    input  ram_ack, ld_addr,
    output st_ready, st_addr_err,
    output ram_req, ram_addr, ram_wstrb, ram_wdata,
    output ld_hit, buf_empty, buf_count
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer: aligns MEM-stage stores into byte lanes, queues
// them and drains one per RAM ack; flags loads that hit a queued word.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           resetn,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_nx;

  logic [29:0]      ent_addr [DEPTH];
  logic [3:0]       ent_strb [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nx;

  logic        legal;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic        accept, push, pop;
  logic        err_q, hit;

  always_comb begin
    legal = 1'b0;
    strb  = 4'b0000;
    wdata = bus.st_data;
    unique case (1'b1)
      (bus.st_sel == 4'b0001): begin
        legal = 1'b1;
        strb  = 4'b0001 << bus.st_addr[1:0];
        wdata = {4{bus.st_data[7:0]}};
      end
      (bus.st_sel == 4'b0011): begin
        legal = ~bus.st_addr[0];
        strb  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.st_data[15:0]}};
      end
      (bus.st_sel == 4'b1111): begin
        legal = (bus.st_addr[1:0] == 2'b00);
        strb  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign accept   = bus.st_valid & bus.st_ready;
  assign push     = accept & legal;
  assign pop      = (state == SEND) & bus.ram_ack;
  assign count_nx = count + CW'(push) - CW'(pop);

  // Enqueue looks at the post-edge count so a store into an
  // empty buffer is presented to RAM in the very next cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (count_nx != '0) state_nx = SEND;
      SEND:    if (count_nx == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ent_vld <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      err_q <= accept & ~legal;
      if (pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + 1'b1;
      end
      if (push) begin
        ent_vld[wptr] <= 1'b1;
        wptr          <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wptr] <= bus.st_addr[31:2];
      ent_strb[wptr] <= strb;
      ent_data[wptr] <= wdata;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == bus.ld_addr[31:2]) hit = 1'b1;
    end
  end

  assign bus.st_ready    = (count < FULL);
  assign bus.st_addr_err = err_q;
  assign bus.ram_req     = (state == SEND);
  assign bus.ram_addr    = bus.ram_req ? {ent_addr[rptr], 2'b00} : '0;
  assign bus.ram_wstrb   = bus.ram_req ? ent_strb[rptr] : '0;
  assign bus.ram_wdata   = bus.ram_req ? ent_data[rptr] : '0;
  assign bus.ld_hit      = hit;
  assign bus.buf_empty   = (count == '0);
  assign bus.buf_count   = count;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, rejection, fill/stall,
// FIFO drain order, load hazard and reset during a pending request.
module tb_store_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;

  store_buffer_if #(.DEPTH(4)) bus ();

  store_buffer #(.DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.st_valid = 0;
    bus.st_addr  = 0;
    bus.st_sel   = 0;
    bus.st_data  = 0;
    bus.ram_ack  = 0;
    bus.ld_addr  = 0;
    resetn = 0;
    tick();
    tick();
    resetn = 1;
    #1;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.st_ready); end
    checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus.buf_empty); end
    checks++; if (bus.ld_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", bus.ld_hit); end
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.ram_req); end
    checks++; if (bus.st_addr_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.st_addr_err); end
    checks++; if (bus.buf_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.buf_count); end
    checks++; if ({bus.ram_addr, bus.ram_wstrb, bus.ram_wdata} !== 68'h0) begin failures++; $display("FAIL rst_ram got=%h/%b/%h exp=0", bus.ram_addr, bus.ram_wstrb, bus.ram_wdata); end
  endtask

  task automatic test_byte();
    bus.st_valid = 1;
    bus.st_addr  = 32'h8000_0013;
    bus.st_sel   = 4'b0001;
    bus.st_data  = 32'h0000_00A5;
    tick();
    bus.st_valid = 0;
    bus.ld_addr  = 32'h8000_0011;
    #1;
    checks++; if (bus.ram_req !== 1'b1) begin failures++; $display("FAIL byte_req got=%b exp=1", bus.ram_req); end
    checks++; if (bus.ram_addr !== 32'h8000_0010) begin failures++; $display("FAIL byte_addr got=%h exp=80000010", bus.ram_addr); end
    checks++; if (bus.ram_wstrb !== 4'b1000) begin failures++; $display("FAIL byte_strb got=%b exp=1000", bus.ram_wstrb); end
    checks++; if (bus.ram_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL byte_data got=%h exp=a5a5a5a5", bus.ram_wdata); end
    checks++; if (bus.buf_count !== 3'd1) begin failures++; $display("FAIL byte_count got=%0d exp=1", bus.buf_count); end
    checks++; if (bus.ld_hit !== 1'b1) begin failures++; $display("FAIL byte_hit got=%b exp=1", bus.ld_hit); end
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL byte_idle got=%b exp=0", bus.ram_req); end
    checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL byte_empty got=%b exp=1", bus.buf_empty); end
  endtask

  task automatic test_half();
    bus.st_valid = 1;
    bus.st_addr  = 32'h0000_0202;
    bus.st_sel   = 4'b0011;
    bus.st_data  = 32'h1234_BEEF;
    tick();
    bus.st_addr  = 32'h0000_0200;
    bus.st_data  = 32'h0000_CAFE;
    #1;
    checks++; if (bus.ram_addr !== 32'h200) begin failures++; $display("FAIL half_addr got=%h exp=200", bus.ram_addr); end
    checks++; if (bus.ram_wstrb !== 4'b1100) begin failures++; $display("FAIL half_strb_hi got=%b exp=1100", bus.ram_wstrb); end
    checks++; if (bus.ram_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL half_data_hi got=%h exp=beefbeef", bus.ram_wdata); end
    tick();
    bus.st_valid = 0;
    #1;
    checks++; if (bus.buf_count !== 3'd2) begin failures++; $display("FAIL half_count got=%0d exp=2", bus.buf_count); end
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.ram_req !== 1'b1) begin failures++; $display("FAIL half_b2b got=%b exp=1", bus.ram_req); end
    checks++; if (bus.ram_wstrb !== 4'b0011) begin failures++; $display("FAIL half_strb_lo got=%b exp=0011", bus.ram_wstrb); end
    checks++; if (bus.ram_wdata !== 32'hCAFE_CAFE) begin failures++; $display("FAIL half_data_lo got=%h exp=cafecafe", bus.ram_wdata); end
    checks++; if (bus.buf_count !== 3'd1) begin failures++; $display("FAIL half_count1 got=%0d exp=1", bus.buf_count); end
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL half_empty got=%b exp=1", bus.buf_empty); end
  endtask

  task automatic test_misaligned();
    bus.st_valid = 1;
    bus.st_addr  = 32'h0000_0101;
    bus.st_sel   = 4'b0011;
    tick();
    bus.st_addr  = 32'h0000_0102;
    bus.st_sel   = 4'b1111;
    #1;
    checks++; if (bus.st_addr_err !== 1'b1) begin failures++; $display("FAIL mis_half_err got=%b exp=1", bus.st_addr_err); end
    checks++; if (bus.buf_count !== 3'd0) begin failures++; $display("FAIL mis_half_count got=%0d exp=0", bus.buf_count); end
    tick();
    bus.st_addr  = 32'h0000_0100;
    bus.st_sel   = 4'b0101;
    #1;
    checks++; if (bus.st_addr_err !== 1'b1) begin failures++; $display("FAIL mis_word_err got=%b exp=1", bus.st_addr_err); end
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", bus.ram_req); end
    tick();
    bus.st_valid = 0;
    #1;
    checks++; if (bus.st_addr_err !== 1'b1) begin failures++; $display("FAIL mis_sel_err got=%b exp=1", bus.st_addr_err); end
    tick();
    checks++; if (bus.st_addr_err !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", bus.st_addr_err); end
    checks++; if (bus.buf_count !== 3'd0) begin failures++; $display("FAIL mis_count got=%0d exp=0", bus.buf_count); end
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL mis_req2 got=%b exp=0", bus.ram_req); end
  endtask

  task automatic test_fill_stall();
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      bus.st_valid = 1;
      bus.st_addr  = 32'h1000 + 32'(4 * k);
      bus.st_sel   = 4'b1111;
      bus.st_data  = 32'h1111_1111 * 32'(k + 1);
      tick();
    end
    bus.st_addr = 32'h1010;
    bus.st_data = 32'h5555_5555;
    #1;
    checks++; if (bus.buf_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.buf_count); end
    checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", bus.st_ready); end
    checks++; if (bus.ram_addr !== 32'h1000) begin failures++; $display("FAIL fill_head got=%h exp=1000", bus.ram_addr); end
    tick();
    checks++; if (bus.buf_count !== 3'd4) begin failures++; $display("FAIL fill_stall got=%0d exp=4", bus.buf_count); end
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.buf_count !== 3'd3) begin failures++; $display("FAIL fill_pop got=%0d exp=3", bus.buf_count); end
    checks++; if (bus.ram_req !== 1'b1) begin failures++; $display("FAIL fill_req got=%b exp=1", bus.ram_req); end
    checks++; if (bus.ram_addr !== 32'h1004) begin failures++; $display("FAIL fill_second got=%h exp=1004", bus.ram_addr); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL fill_ready1 got=%b exp=1", bus.st_ready); end
    tick();
    bus.st_valid = 0;
    #1;
    checks++; if (bus.buf_count !== 3'd4) begin failures++; $display("FAIL fill_fifth got=%0d exp=4", bus.buf_count); end
    bus.ram_ack = 1;
    for (int k = 1; k < 5; k++) begin
      exp_a = 32'h1000 + 32'(4 * k);
      exp_d = 32'h1111_1111 * 32'(k + 1);
      checks++; if (bus.ram_addr !== exp_a || bus.ram_wdata !== exp_d) begin failures++; $display("FAIL drain_%0d got=%h/%h exp=%h/%h", k, bus.ram_addr, bus.ram_wdata, exp_a, exp_d); end
      tick();
    end
    bus.ram_ack = 0;
    checks++; if (bus.buf_count !== 3'd0 || bus.ram_req !== 1'b0) begin failures++; $display("FAIL drain_done got=%0d/%b exp=0/0", bus.buf_count, bus.ram_req); end
  endtask

  task automatic test_hazard();
    bus.ld_addr  = 32'h100;
    bus.st_valid = 1;
    bus.st_addr  = 32'h100;
    bus.st_sel   = 4'b1111;
    bus.st_data  = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.ld_hit !== 1'b0) begin failures++; $display("FAIL haz_pre got=%b exp=0", bus.ld_hit); end
    tick();
    bus.st_valid = 0;
    bus.ld_addr  = 32'h103;
    #1;
    checks++; if (bus.ld_hit !== 1'b1) begin failures++; $display("FAIL haz_hit got=%b exp=1", bus.ld_hit); end
    bus.ld_addr = 32'h104;
    #1;
    checks++; if (bus.ld_hit !== 1'b0) begin failures++; $display("FAIL haz_next got=%b exp=0", bus.ld_hit); end
    bus.ld_addr = 32'h103;
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.ld_hit !== 1'b0) begin failures++; $display("FAIL haz_drained got=%b exp=0", bus.ld_hit); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.st_valid = 1;
      bus.st_addr  = 32'h300 + 32'(4 * k);
      bus.st_sel   = 4'b1111;
      bus.st_data  = 32'(k);
      tick();
    end
    bus.st_valid = 0;
    bus.ld_addr  = 32'h300;
    #1;
    checks++; if (bus.buf_count !== 3'd3 || bus.ram_req !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=3/1", bus.buf_count, bus.ram_req); end
    resetn = 0;
    tick();
    resetn = 1;
    #1;
    checks++; if (bus.buf_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.buf_count); end
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%b exp=0", bus.ram_req); end
    checks++; if (bus.buf_empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b exp=1", bus.buf_empty); end
    checks++; if (bus.ram_addr !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", bus.ram_addr); end
    checks++; if (bus.ld_hit !== 1'b0) begin failures++; $display("FAIL mid_hit got=%b exp=0", bus.ld_hit); end
    bus.ram_ack = 1;
    tick();
    bus.ram_ack = 0;
    #1;
    checks++; if (bus.buf_count !== 3'd0 || bus.ram_req !== 1'b0) begin failures++; $display("FAIL mid_ack got=%0d/%b exp=0/0", bus.buf_count, bus.ram_req); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misaligned();
    test_fill_stall();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
